// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// InstructionFetch front end: owns the program counter and the IF/ID pipeline
// register. The PC goes straight out to instruction memory and the word that
// comes back in the same cycle is captured into IF/ID on the next rising edge.
//
// Ports
//   clk              single clock, all state changes on the rising edge
//   reset            synchronous active-high reset
//   start            level, moves IDLE -> RUN
//   stall            level, decode hazard hold
//   branch_taken     one-cycle redirect request
//   branch_target    redirect byte address (low two bits forced to zero)
//   halt             one-cycle stop request
//   Inst_Address     byte address to instruction memory (always the PC)
//   Instruction      word returned combinationally for Inst_Address
//   ifid_pc          PC of the word held in IF/ID
//   ifid_instruction word held in IF/ID
//   ifid_valid       IF/ID holds a real instruction
//   fetch_count      number of words delivered into IF/ID (wraps silently)
//   misalign_err     sticky flag, set by a redirect to a non word-aligned target
//   state            IDLE=0, RUN=1, HALTED=2
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        halt,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

  fetchState_t r_state;
  logic [63:0] r_pc;
  logic [63:0] r_ifidPc;
  logic [31:0] r_ifidInstr;
  logic        r_ifidValid;
  logic [31:0] r_fetchCount;
  logic        r_misalign;

  fetchState_t w_nextState;
  logic [63:0] w_nextPc;
  logic [63:0] w_nextIfidPc;
  logic [31:0] w_nextIfidInstr;
  logic        w_nextIfidValid;
  logic [31:0] w_nextFetchCount;
  logic        w_nextMisalign;

  // Next-state logic. Everything holds by default; within RUN the events are
  // resolved halt first, then redirect, then stall, then a plain fetch. A
  // redirect wins over stall because the word currently in IF/ID belongs to
  // the wrong path and must be squashed regardless of the decode hazard.
  always_comb begin
    w_nextState      = r_state;
    w_nextPc         = r_pc;
    w_nextIfidPc     = r_ifidPc;
    w_nextIfidInstr  = r_ifidInstr;
    w_nextIfidValid  = r_ifidValid;
    w_nextFetchCount = r_fetchCount;
    w_nextMisalign   = r_misalign;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          w_nextState     = HALTED;
          w_nextIfidInstr = NOP_WORD;
          w_nextIfidValid = 1'b0;
        end else if (branch_taken) begin
          w_nextPc        = {branch_target[63:2], 2'b00};
          w_nextIfidInstr = NOP_WORD;
          w_nextIfidValid = 1'b0;
          if (branch_target[1:0] != 2'b00) begin
            w_nextMisalign = 1'b1;
          end
        end else if (!stall) begin
          w_nextIfidInstr  = Instruction;
          w_nextIfidPc     = r_pc;
          w_nextIfidValid  = 1'b1;
          w_nextPc         = r_pc + 64'd4;
          w_nextFetchCount = r_fetchCount + 32'd1;
        end
      end
      HALTED: begin
      end
      // The unused encoding falls back to IDLE so a corrupted state register
      // cannot lock the unit up.
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register. Reset is synchronous and overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_ifidPc     <= 64'd0;
      r_ifidInstr  <= NOP_WORD;
      r_ifidValid  <= 1'b0;
      r_fetchCount <= 32'd0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_ifidPc     <= w_nextIfidPc;
      r_ifidInstr  <= w_nextIfidInstr;
      r_ifidValid  <= w_nextIfidValid;
      r_fetchCount <= w_nextFetchCount;
      r_misalign   <= w_nextMisalign;
    end
  end

  assign Inst_Address     = r_pc;
  assign ifid_pc          = r_ifidPc;
  assign ifid_instruction = r_ifidInstr;
  assign ifid_valid       = r_ifidValid;
  assign fetch_count      = r_fetchCount;
  assign misalign_err     = r_misalign;
  assign state            = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for instruction_fetch. A small behavioural memory answers
// Inst_Address combinationally. A table of per-cycle records drives the main
// run/stall/redirect/halt sequence; hand-written sequences cover reset
// behaviour, misalign stickiness, IDLE immunity, mid-run reset and PC wrap.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branchTaken;
  logic [63:0] branchTarget;
  logic        halt;
  logic [63:0] instAddress;
  logic [31:0] instruction;
  logic [63:0] ifidPc;
  logic [31:0] ifidInstruction;
  logic        ifidValid;
  logic [31:0] fetchCount;
  logic        misalignErr;
  logic [1:0]  state;

  int total;
  int bad;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stall            (stall),
    .branch_taken     (branchTaken),
    .branch_target    (branchTarget),
    .halt             (halt),
    .Inst_Address     (instAddress),
    .Instruction      (instruction),
    .ifid_pc          (ifidPc),
    .ifid_instruction (ifidInstruction),
    .ifid_valid       (ifidValid),
    .fetch_count      (fetchCount),
    .misalign_err     (misalignErr),
    .state            (state)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: the two words from the sequential-fetch scenario, and an
  // address-derived pattern everywhere else so each word is distinguishable.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'd0)      return 32'h009A84B3;
    else if (a == 64'd4) return 32'h00148493;
    else                 return a[31:0] ^ 32'h5A5A0000;
  endfunction

  always_comb instruction = memWord(instAddress);

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [63:0] target;
    logic        halt;
    logic [63:0] expPc;
    logic [63:0] expIfidPc;
    logic [31:0] expInstr;
    logic        expValid;
    logic [31:0] expCount;
    logic        expMis;
    logic [1:0]  expState;
  } vector_t;

  vector_t vecs[13];

  // Drive one set of inputs; called right after a check, away from the edge.
  task automatic applyStimulus(input logic s, input logic st, input logic b,
                               input logic [63:0] t, input logic h, input logic r);
    start        = s;
    stall        = st;
    branchTaken  = b;
    branchTarget = t;
    halt         = h;
    reset        = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                             input logic [31:0] ins, input logic v, input logic [31:0] cnt,
                             input logic mis, input logic [1:0] st);
    checkField({tag, ".pc"},        instAddress,     pc);
    checkField({tag, ".ifid_pc"},   ifidPc,          ipc);
    checkField({tag, ".ifid_ins"},  {32'd0, ifidInstruction}, {32'd0, ins});
    checkField({tag, ".valid"},     {63'd0, ifidValid},   {63'd0, v});
    checkField({tag, ".count"},     {32'd0, fetchCount},  {32'd0, cnt});
    checkField({tag, ".misalign"},  {63'd0, misalignErr}, {63'd0, mis});
    checkField({tag, ".state"},     {62'd0, state},       {62'd0, st});
  endtask

  task automatic checkReset(input string tag);
    checkOutput(tag, 64'd0, 64'd0, NOP, 1'b0, 32'd0, 1'b0, 2'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //                start stall br target     halt  pc       ifidPc  instr                 v  cnt mis st
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0,  64'h0,  NOP,                  1'b0, 0, 1'b0, 2'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h4,  64'h0,  32'h009A84B3,         1'b1, 1, 1'b0, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h4,  64'h0,  32'h009A84B3,         1'b1, 1, 1'b0, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h4,  64'h0,  32'h009A84B3,         1'b1, 1, 1'b0, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 64'h4,  64'h0,  32'h009A84B3,         1'b1, 1, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h8,  64'h4,  32'h00148493,         1'b1, 2, 1'b0, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 64'h40,  1'b0, 64'h40, 64'h4,  NOP,                  1'b0, 2, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h44, 64'h40, memWord(64'h40),      1'b1, 3, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h46,  1'b0, 64'h44, 64'h40, NOP,                  1'b0, 3, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 64'h48, 64'h44, memWord(64'h44),      1'b1, 4, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 64'h48, 64'h44, NOP,                  1'b0, 4, 1'b1, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h48, 64'h44, NOP,                  1'b0, 4, 1'b1, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 64'h80,  1'b1, 64'h48, 64'h44, NOP,                  1'b0, 4, 1'b1, 2'd2};

    // Reset from power-up.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    stepCycle();
    stepCycle();
    checkReset("reset");

    // Main table: run, stall, redirect under stall, misaligned redirect, halt.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].target, vecs[i].halt, 1'b0);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expIfidPc, vecs[i].expInstr,
                  vecs[i].expValid, vecs[i].expCount, vecs[i].expMis, vecs[i].expState);
    end

    // Misalign flag stays set for 10 more cycles, then reset clears everything.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) stepCycle();
    checkField("misalign_sticky", {63'd0, misalignErr}, 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h200, 1'b1, 1'b1);
    stepCycle();
    checkReset("reset_from_halted");

    // IDLE ignores redirect and halt.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h300, 1'b1, 1'b0);
    stepCycle();
    checkReset("idle_ignore");

    // Run five fetches, then reset mid-redirect while stalled.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("five_fetch", 64'd20, 64'd16, memWord(64'd16), 1'b1, 32'd5, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h47, 1'b0, 1'b1);
    stepCycle();
    checkReset("midrun_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    stepCycle();
    checkReset("idle_after_reset");

    // PC wraps modulo 2^64 after a fetch at the top word.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("pc_wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, memWord(64'hFFFF_FFFF_FFFF_FFFC),
                1'b1, 32'd1, 1'b0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, byte address loaded into the PC on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000013, bubble instruction written into IF/ID on flush or halt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; moves the unit from IDLE to RUN.
REQ-006 stall  input  1  level; hazard hold from decode.
REQ-007 branch_taken  input  1  one-cycle redirect request.
REQ-008 branch_target  input  64  redirect byte address.
REQ-009 halt  input  1  one-cycle stop request.
REQ-010 Inst_Address  output  64  byte address to instruction memory, always equal to pc.
REQ-011 Instruction  input  32  little-endian word returned combinationally by instruction memory for Inst_Address.
REQ-012 ifid_pc  output  64  registered PC of the word in IF/ID.
REQ-013 ifid_instruction  output  32  registered fetched word.
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 fetch_count  output  32  number of words delivered into IF/ID.
REQ-016 misalign_err  output  1  sticky flag for a redirect target with bits [1:0] not equal to 0.
REQ-017 state  output  2  IDLE=0, RUN=1, HALTED=2; encoding 3 is unused.

Function
REQ-018 The unit SHALL drive Inst_Address = pc combinationally with zero latency and SHALL accept Instruction in the same cycle.
REQ-019 IDLE: pc, IF/ID and fetch_count SHALL hold; branch_taken and halt SHALL be ignored; start=1 SHALL move the unit to RUN on the next edge without a fetch in that cycle.
REQ-020 In RUN, events SHALL be resolved in this priority order: halt > branch_taken > stall > normal fetch.
REQ-021 Normal fetch in RUN:
  - ifid_instruction <= Instruction
  - ifid_pc <= pc
  - ifid_valid <= 1
  - pc <= pc+4
  - fetch_count <= fetch_count+1
REQ-022 Stall in RUN: pc, ifid_pc, ifid_instruction, ifid_valid and fetch_count SHALL hold.
REQ-023 Redirect in RUN, including while stall=1:
  - pc <= {branch_target[63:2], 2'b00}
  - ifid_instruction <= NOP_WORD
  - ifid_valid <= 0
  - ifid_pc holds
  - fetch_count holds
REQ-024 A redirect whose branch_target[1:0] is not 0 SHALL set misalign_err=1 on the same edge; misalign_err SHALL stay set until reset.
REQ-025 Halt in RUN: state <= HALTED, ifid_valid <= 0, ifid_instruction <= NOP_WORD, pc and fetch_count SHALL hold, and any simultaneous branch_taken SHALL be discarded.
REQ-026 HALTED SHALL be exited only by reset; start, stall, branch_taken and halt SHALL have no effect in HALTED.
REQ-027 pc SHALL wrap modulo 2^64; fetch_count SHALL wrap modulo 2^32 with no flag.
REQ-028 The latency from redirect to the first valid target word in IF/ID SHALL be 2 edges: a bubble edge, then the target word.

Reset
REQ-029 When reset=1 at an edge, the unit SHALL set:
  - pc=RESET_PC (so Inst_Address=RESET_PC)
  - ifid_pc=0, ifid_instruction=NOP_WORD, ifid_valid=0
  - fetch_count=0, misalign_err=0
  - state=IDLE
REQ-030 Reset SHALL override every other input in every state, including a mid-stall, mid-redirect or HALTED cycle.

Verification
REQ-031 Sequential fetch: memory holds 0x009A84B3 at address 0 and 0x00148493 at address 4; reset, then start, then 2 run cycles -> IF/ID shows (0, 0x009A84B3, valid) then (4, 0x00148493, valid); pc=8; fetch_count=2.
REQ-032 Stall: assert stall for 3 cycles after the first fetch -> ifid_pc stays 0, pc stays 4 and fetch_count stays 1 throughout; the 4-byte word is delivered on the first cycle after release.
REQ-033 Redirect under stall: stall=1 with branch_taken=1 and target 0x40 -> ifid_valid=0, ifid_instruction=0x00000013, pc=0x40; the next edge loads ifid_pc=0x40.
REQ-034 Misaligned target: branch_target 0x46 -> pc=0x44, misalign_err=1 and still 1 after 10 further cycles; reset clears it to 0.
REQ-035 Halt with branch: halt=1 and branch_taken=1 in the same cycle -> state=HALTED, pc unchanged, ifid_valid=0; a later start has no effect.
REQ-036 Mid-run reset: reset at fetch_count=5 -> every output returns to its REQ-029 value at the next edge, and state=IDLE until start.
